// File: rtl/decode_stage.sv
// decode_stage: RV32I instruction decode stage with register file and ID/EX register.
//
// Decodes the instruction held in IF/ID, reads the register file (with same-cycle
// write-back bypass), builds the sign-extended immediate and control word, and
// registers everything into ID/EX for the execute stage.
//
// Ports:
//   clk, rst            clock; synchronous active-low reset
//   InstrD, PCD, PCPlus4D   IF/ID contents
//   FlushE              turn the next ID/EX contents into a bubble
//   RegWriteW, RdW, ResultW register-file write-back port
//   *E outputs          registered ID/EX contents (control, data, register indices)
module decode_stage #(
  parameter int unsigned RF_DEPTH = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] InstrD,
  input  logic [31:0] PCD,
  input  logic [31:0] PCPlus4D,
  input  logic        FlushE,
  input  logic        RegWriteW,
  input  logic [4:0]  RdW,
  input  logic [31:0] ResultW,
  output logic        RegWriteE,
  output logic        MemWriteE,
  output logic        JumpE,
  output logic        BranchE,
  output logic [1:0]  ResultSrcE,
  output logic [1:0]  ALUSrcAE,
  output logic        ALUSrcBE,
  output logic [3:0]  ALUControlE,
  output logic [2:0]  Funct3E,
  output logic [31:0] RD1E,
  output logic [31:0] RD2E,
  output logic [31:0] ImmExtE,
  output logic [31:0] PCE,
  output logic [31:0] PCPlus4E,
  output logic [4:0]  Rs1E,
  output logic [4:0]  Rs2E,
  output logic [4:0]  RdE
);

  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpRType  = 7'b0110011;
  localparam logic [6:0] OpIAlu   = 7'b0010011;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpJalr   = 7'b1100111;
  localparam logic [6:0] OpLui    = 7'b0110111;
  localparam logic [6:0] OpAuipc  = 7'b0010111;

  localparam logic [3:0] AluAdd  = 4'b0000;
  localparam logic [3:0] AluSub  = 4'b0001;
  localparam logic [3:0] AluAnd  = 4'b0010;
  localparam logic [3:0] AluOr   = 4'b0011;
  localparam logic [3:0] AluXor  = 4'b0100;
  localparam logic [3:0] AluSlt  = 4'b0101;
  localparam logic [3:0] AluSltu = 4'b0110;
  localparam logic [3:0] AluSll  = 4'b0111;
  localparam logic [3:0] AluSrl  = 4'b1000;
  localparam logic [3:0] AluSra  = 4'b1001;

  typedef enum logic [2:0] {ImmNone, ImmI, ImmS, ImmB, ImmJ, ImmU} imm_src_e;
  typedef enum logic [1:0] {AluOpAdd, AluOpSub, AluOpFunct} alu_op_e;

  typedef struct packed {
    logic        reg_write;
    logic        mem_write;
    logic        jump;
    logic        branch;
    logic [1:0]  result_src;
    logic [1:0]  alu_src_a;
    logic        alu_src_b;
    logic [3:0]  alu_control;
    logic [2:0]  funct3;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] imm_ext;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
  } idex_t;

  // Instruction fields
  logic [6:0] opcode;
  logic [4:0] rd_d, rs1_d, rs2_d;
  logic [2:0] funct3_d;
  logic       funct7b5;

  assign opcode   = InstrD[6:0];
  assign rd_d     = InstrD[11:7];
  assign funct3_d = InstrD[14:12];
  assign rs1_d    = InstrD[19:15];
  assign rs2_d    = InstrD[24:20];
  assign funct7b5 = InstrD[30];

  // Main decoder
  logic     reg_write_d, mem_write_d, jump_d, branch_d, alu_src_b_d, is_rtype;
  logic [1:0] result_src_d, alu_src_a_d;
  imm_src_e imm_src;
  alu_op_e  alu_op;

  always_comb begin
    reg_write_d  = 1'b0;
    mem_write_d  = 1'b0;
    jump_d       = 1'b0;
    branch_d     = 1'b0;
    result_src_d = 2'b00;
    alu_src_a_d  = 2'b00;
    alu_src_b_d  = 1'b0;
    imm_src      = ImmNone;
    alu_op       = AluOpAdd;
    is_rtype     = 1'b0;
    unique case (opcode)
      OpLoad: begin
        reg_write_d  = 1'b1;
        alu_src_b_d  = 1'b1;
        result_src_d = 2'b01;
        imm_src      = ImmI;
      end
      OpStore: begin
        mem_write_d = 1'b1;
        alu_src_b_d = 1'b1;
        imm_src     = ImmS;
      end
      OpRType: begin
        reg_write_d = 1'b1;
        alu_op      = AluOpFunct;
        is_rtype    = 1'b1;
      end
      OpIAlu: begin
        reg_write_d = 1'b1;
        alu_src_b_d = 1'b1;
        imm_src     = ImmI;
        alu_op      = AluOpFunct;
      end
      OpBranch: begin
        branch_d = 1'b1;
        imm_src  = ImmB;
        alu_op   = AluOpSub;
      end
      OpJal: begin
        jump_d       = 1'b1;
        reg_write_d  = 1'b1;
        result_src_d = 2'b10;
        alu_src_a_d  = 2'b01;
        alu_src_b_d  = 1'b1;
        imm_src      = ImmJ;
      end
      OpJalr: begin
        jump_d       = 1'b1;
        reg_write_d  = 1'b1;
        result_src_d = 2'b10;
        alu_src_b_d  = 1'b1;
        imm_src      = ImmI;
      end
      // lui computes 0 + imm, auipc computes PC + imm; both write rd.
      OpLui: begin
        reg_write_d = 1'b1;
        alu_src_a_d = 2'b10;
        alu_src_b_d = 1'b1;
        imm_src     = ImmU;
      end
      OpAuipc: begin
        reg_write_d = 1'b1;
        alu_src_a_d = 2'b01;
        alu_src_b_d = 1'b1;
        imm_src     = ImmU;
      end
      default: ;
    endcase
  end

  // ALU decoder
  logic [3:0] alu_control_d;

  always_comb begin
    alu_control_d = AluAdd;
    unique case (alu_op)
      AluOpSub: alu_control_d = AluSub;
      AluOpFunct: begin
        unique case (funct3_d)
          3'b000:  alu_control_d = (is_rtype && funct7b5) ? AluSub : AluAdd;
          3'b001:  alu_control_d = AluSll;
          3'b010:  alu_control_d = AluSlt;
          3'b011:  alu_control_d = AluSltu;
          3'b100:  alu_control_d = AluXor;
          3'b101:  alu_control_d = funct7b5 ? AluSra : AluSrl;
          3'b110:  alu_control_d = AluOr;
          default: alu_control_d = AluAnd;
        endcase
      end
      default: alu_control_d = AluAdd;
    endcase
  end

  // Immediate generator
  logic [31:0] imm_ext_d;

  always_comb begin
    imm_ext_d = 32'h0;
    unique case (imm_src)
      ImmI: imm_ext_d = {{20{InstrD[31]}}, InstrD[31:20]};
      ImmS: imm_ext_d = {{20{InstrD[31]}}, InstrD[31:25], InstrD[11:7]};
      ImmB: imm_ext_d = {{20{InstrD[31]}}, InstrD[7], InstrD[30:25], InstrD[11:8], 1'b0};
      ImmJ: imm_ext_d = {{12{InstrD[31]}}, InstrD[19:12], InstrD[20], InstrD[30:21], 1'b0};
      ImmU: imm_ext_d = {InstrD[31:12], 12'h0};
      default: imm_ext_d = 32'h0;
    endcase
  end

  // Register file
  logic [31:0] rf_q [RF_DEPTH];
  logic [31:0] rf_d [RF_DEPTH];
  logic        wb_en;
  logic [31:0] rd1_d, rd2_d;

  assign wb_en = RegWriteW && (RdW != 5'd0) && (32'(RdW) < RF_DEPTH);

  always_comb begin
    for (int i = 0; i < int'(RF_DEPTH); i++) begin
      rf_d[i] = rf_q[i];
    end
    if (wb_en) begin
      rf_d[RdW] = ResultW;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < int'(RF_DEPTH); i++) begin
      if (!rst) begin
        rf_q[i] <= 32'h0;
      end else begin
        rf_q[i] <= rf_d[i];
      end
    end
  end

  // Reads see a same-cycle write-back so WB->ID needs no hazard handling.
  always_comb begin
    rd1_d = 32'h0;
    rd2_d = 32'h0;
    if (rs1_d != 5'd0 && 32'(rs1_d) < RF_DEPTH) begin
      rd1_d = (wb_en && RdW == rs1_d) ? ResultW : rf_q[rs1_d];
    end
    if (rs2_d != 5'd0 && 32'(rs2_d) < RF_DEPTH) begin
      rd2_d = (wb_en && RdW == rs2_d) ? ResultW : rf_q[rs2_d];
    end
  end

  // ID/EX pipeline register
  idex_t idex_d, idex_q;

  always_comb begin
    idex_d = '0;
    if (!FlushE) begin
      idex_d.reg_write   = reg_write_d;
      idex_d.mem_write   = mem_write_d;
      idex_d.jump        = jump_d;
      idex_d.branch      = branch_d;
      idex_d.result_src  = result_src_d;
      idex_d.alu_src_a   = alu_src_a_d;
      idex_d.alu_src_b   = alu_src_b_d;
      idex_d.alu_control = alu_control_d;
      idex_d.funct3      = funct3_d;
      idex_d.rd1         = rd1_d;
      idex_d.rd2         = rd2_d;
      idex_d.imm_ext     = imm_ext_d;
      idex_d.pc          = PCD;
      idex_d.pc_plus4    = PCPlus4D;
      idex_d.rs1         = rs1_d;
      idex_d.rs2         = rs2_d;
      idex_d.rd          = rd_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      idex_q <= '0;
    end else begin
      idex_q <= idex_d;
    end
  end

  assign RegWriteE   = idex_q.reg_write;
  assign MemWriteE   = idex_q.mem_write;
  assign JumpE       = idex_q.jump;
  assign BranchE     = idex_q.branch;
  assign ResultSrcE  = idex_q.result_src;
  assign ALUSrcAE    = idex_q.alu_src_a;
  assign ALUSrcBE    = idex_q.alu_src_b;
  assign ALUControlE = idex_q.alu_control;
  assign Funct3E     = idex_q.funct3;
  assign RD1E        = idex_q.rd1;
  assign RD2E        = idex_q.rd2;
  assign ImmExtE     = idex_q.imm_ext;
  assign PCE         = idex_q.pc;
  assign PCPlus4E    = idex_q.pc_plus4;
  assign Rs1E        = idex_q.rs1;
  assign Rs2E        = idex_q.rs2;
  assign RdE         = idex_q.rd;

endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: directed self-checking bench for decode_stage.
module tb_decode_stage;

  logic        clk;
  logic        rst;
  logic [31:0] InstrD, PCD, PCPlus4D;
  logic        FlushE;
  logic        RegWriteW;
  logic [4:0]  RdW;
  logic [31:0] ResultW;
  logic        RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcBE;
  logic [1:0]  ResultSrcE, ALUSrcAE;
  logic [3:0]  ALUControlE;
  logic [2:0]  Funct3E;
  logic [31:0] RD1E, RD2E, ImmExtE, PCE, PCPlus4E;
  logic [4:0]  Rs1E, Rs2E, RdE;

  int n_total = 0;
  int n_bad   = 0;

  decode_stage #(.RF_DEPTH(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .InstrD      (InstrD),
    .PCD         (PCD),
    .PCPlus4D    (PCPlus4D),
    .FlushE      (FlushE),
    .RegWriteW   (RegWriteW),
    .RdW         (RdW),
    .ResultW     (ResultW),
    .RegWriteE   (RegWriteE),
    .MemWriteE   (MemWriteE),
    .JumpE       (JumpE),
    .BranchE     (BranchE),
    .ResultSrcE  (ResultSrcE),
    .ALUSrcAE    (ALUSrcAE),
    .ALUSrcBE    (ALUSrcBE),
    .ALUControlE (ALUControlE),
    .Funct3E     (Funct3E),
    .RD1E        (RD1E),
    .RD2E        (RD2E),
    .ImmExtE     (ImmExtE),
    .PCE         (PCE),
    .PCPlus4E    (PCPlus4E),
    .Rs1E        (Rs1E),
    .Rs2E        (Rs2E),
    .RdE         (RdE)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Apply inputs, clock one edge, sample 1 time unit later.
  task automatic step(input logic [31:0] instr, input logic [31:0] pc, input logic flush,
                      input logic wb_we, input logic [4:0] wb_rd, input logic [31:0] wb_data);
    InstrD    = instr;
    PCD       = pc;
    PCPlus4D  = pc + 32'd4;
    FlushE    = flush;
    RegWriteW = wb_we;
    RdW       = wb_rd;
    ResultW   = wb_data;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    step(32'h0, 32'h0, 1'b0, 1'b1, 5'd5, 32'hAAAA5555);

    // Reset with a live instruction in IF/ID: everything must clear.
    rst = 1'b0;
    step(32'h006280B3, 32'h100, 1'b0, 1'b0, 5'd0, 32'h0);
    step(32'h006280B3, 32'h100, 1'b0, 1'b0, 5'd0, 32'h0);
    check_eq("rst_regwrite", 32'(RegWriteE), 32'h0);
    check_eq("rst_pc", PCE, 32'h0);
    check_eq("rst_pcplus4", PCPlus4E, 32'h0);
    check_eq("rst_rd", 32'(RdE), 32'h0);
    check_eq("rst_rs1", 32'(Rs1E), 32'h0);
    rst = 1'b1;

    // x5 written before reset must now read 0.
    step(32'h006280B3, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0);
    check_eq("rst_x5_zero", RD1E, 32'h0);

    // Write x5, then addi x1,x5,0.
    step(32'h0, 32'h0, 1'b0, 1'b1, 5'd5, 32'hDEADBEEF);
    step(32'h00028093, 32'h8, 1'b0, 1'b0, 5'd0, 32'h0);
    check_eq("addi_rd1", RD1E, 32'hDEADBEEF);
    check_eq("addi_imm", ImmExtE, 32'h0);
    check_eq("addi_srcb", 32'(ALUSrcBE), 32'h1);
    check_eq("addi_regwrite", 32'(RegWriteE), 32'h1);
    check_eq("addi_rd", 32'(RdE), 32'h1);
    check_eq("addi_rs1", 32'(Rs1E), 32'h5);
    check_eq("addi_alu", 32'(ALUControlE), 32'h0);

    // Same-cycle bypass: sub x2,x6,x6 while WB writes x6.
    step(32'h40630133, 32'hC, 1'b0, 1'b1, 5'd6, 32'h12345678);
    check_eq("byp_rd1", RD1E, 32'h12345678);
    check_eq("byp_rd2", RD2E, 32'h12345678);
    check_eq("byp_alu_sub", 32'(ALUControlE), 32'h1);
    check_eq("byp_rd", 32'(RdE), 32'h2);

    // x0 protection, both bypass and stored path.
    step(32'h00000033, 32'h10, 1'b0, 1'b1, 5'd0, 32'hFFFFFFFF);
    check_eq("x0_bypass", RD1E, 32'h0);
    step(32'h00000033, 32'h14, 1'b0, 1'b0, 5'd0, 32'h0);
    check_eq("x0_stored", RD1E, 32'h0);

    // Immediates and control
    step(32'hFE112E23, 32'h18, 1'b0, 1'b0, 5'd0, 32'h0);
    check_eq("sw_imm", ImmExtE, 32'hFFFFFFFC);
    check_eq("sw_memwrite", 32'(MemWriteE), 32'h1);
    check_eq("sw_regwrite", 32'(RegWriteE), 32'h0);

    step(32'hFE000EE3, 32'h1C, 1'b0, 1'b0, 5'd0, 32'h0);
    check_eq("beq_imm", ImmExtE, 32'hFFFFFFFC);
    check_eq("beq_branch", 32'(BranchE), 32'h1);
    check_eq("beq_alu", 32'(ALUControlE), 32'h1);

    step(32'h0000006F, 32'h40, 1'b0, 1'b0, 5'd0, 32'h0);
    check_eq("jal_jump", 32'(JumpE), 32'h1);
    check_eq("jal_pc", PCE, 32'h40);
    check_eq("jal_pcplus4", PCPlus4E, 32'h44);
    check_eq("jal_ressrc", 32'(ResultSrcE), 32'h2);
    check_eq("jal_srca", 32'(ALUSrcAE), 32'h1);

    step(32'h4010D093, 32'h44, 1'b0, 1'b0, 5'd0, 32'h0);
    check_eq("srai_alu", 32'(ALUControlE), 32'h9);
    check_eq("srai_imm", ImmExtE, 32'h00000401);

    step(32'h123450B7, 32'h48, 1'b0, 1'b0, 5'd0, 32'h0);
    check_eq("lui_imm", ImmExtE, 32'h12345000);
    check_eq("lui_srca", 32'(ALUSrcAE), 32'h2);

    // Flush: bubble, but the WB write in the same edge still lands.
    step(32'h006280B3, 32'h50, 1'b1, 1'b1, 5'd7, 32'h00000077);
    check_eq("flush_regwrite", 32'(RegWriteE), 32'h0);
    check_eq("flush_rd1", RD1E, 32'h0);
    check_eq("flush_pc", PCE, 32'h0);
    check_eq("flush_rd", 32'(RdE), 32'h0);
    check_eq("flush_rs2", 32'(Rs2E), 32'h0);

    step(32'h006280B3, 32'h54, 1'b0, 1'b0, 5'd0, 32'h0);
    check_eq("post_flush_regwrite", 32'(RegWriteE), 32'h1);
    check_eq("post_flush_rd1", RD1E, 32'hDEADBEEF);
    check_eq("post_flush_rd2", RD2E, 32'h12345678);
    check_eq("post_flush_pc", PCE, 32'h54);

    step(32'h00038093, 32'h58, 1'b0, 1'b0, 5'd0, 32'h0);
    check_eq("flush_wb_x7", RD1E, 32'h77);

    // Reset priority over flush / mid-operation discard.
    rst = 1'b0;
    step(32'h006280B3, 32'h5C, 1'b0, 1'b0, 5'd0, 32'h0);
    check_eq("rst_mid_regwrite", 32'(RegWriteE), 32'h0);
    check_eq("rst_mid_pc", PCE, 32'h0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
# decode_stage

Second stage of the RV32I five-stage pipeline: the consumer of the fetch stage's IF/ID outputs and the producer of the execute stage's inputs. It decodes the instruction, reads the 32x32 register file (written back from WB), generates the sign-extended immediate and the control word, and registers everything into the ID/EX pipeline register. It also accepts a flush from execute when a branch or jump is taken (the same event that drives the fetch redirect).

## Interface
Parameters:
- RF_DEPTH, 32, number of architectural registers (x0 hardwired to zero)

Ports:
- clk  in  1  pipeline clock, all state on rising edge
- rst  in  1  synchronous, active-low reset
- InstrD  in  32  instruction from IF/ID
- PCD  in  32  PC of InstrD
- PCPlus4D  in  32  PCD+4
- FlushE  in  1  taken branch/jump in EX; turns next ID/EX contents into a bubble
- RegWriteW  in  1  WB write enable
- RdW  in  5  WB destination
- ResultW  in  32  WB write data
- RegWriteE, MemWriteE, JumpE, BranchE  out  1 each  registered control
- ResultSrcE  out  2  00 ALU, 01 memory, 10 PC+4
- ALUSrcAE  out  2  00 RD1, 01 PC, 10 zero
- ALUSrcBE  out  1  0 RD2, 1 immediate
- ALUControlE  out  4  0000 add, 0001 sub, 0010 and, 0011 or, 0100 xor, 0101 slt, 0110 sltu, 0111 sll, 1000 srl, 1001 sra
- Funct3E  out  3  branch condition select
- RD1E, RD2E, ImmExtE, PCE, PCPlus4E  out  32 each
- Rs1E, Rs2E, RdE  out  5 each  for the hazard unit

## Operation
- Fields: opcode=Instr[6:0], rd=[11:7], funct3=[14:12], rs1=[19:15], rs2=[24:20], funct7b5=[30].
- Opcode decode: 0000011 load (RegWrite, ALUSrcB=1, ResultSrc=01, I-imm, add); 0100011 store (MemWrite, ALUSrcB=1, S-imm, add); 0110011 R-type; 0010011 I-ALU (ALUSrcB=1, I-imm); 1100011 branch (Branch, B-imm, sub); 1101111 jal (Jump, RegWrite, ResultSrc=10, ALUSrcA=01, ALUSrcB=1, J-imm, add); 1100111 jalr (Jump, RegWrite, ResultSrc=10, ALUSrcB=1, I-imm, add); 0110111 lui (ALUSrcA=10, U-imm); 0010111 auipc (ALUSrcA=01, U-imm). Unlisted opcodes: all control zero (bubble).
- ALU select from funct3: 000 add (sub when R-type and funct7b5=1), 111 and, 110 or, 100 xor, 010 slt, 011 sltu, 001 sll, 101 srl/sra by funct7b5 (both R and I types).
- Immediates sign-extended from Instr[31]: I {[31:20]}, S {[31:25],[11:7]}, B {[31],[7],[30:25],[11:8],0}, J {[31],[19:12],[20],[30:21],0}, U {[31:12],12'b0}.
- Register file: write at rising edge when RegWriteW=1 and RdW!=0; writes to x0 ignored. Reads combinational; x0 always reads 0. Same-cycle bypass: if RegWriteW=1, RdW!=0, RdW equals rs1/rs2, read returns ResultW.
- ID/EX register: rising edge loads decoded values, RD1/RD2, imm, PCD, PCPlus4D, rs1, rs2, rd.

## Timing
- Latency: InstrD present in cycle n -> all E outputs valid after edge n+1. One instruction per cycle, no stall input.
- Reset (rst=0 at edge): every output 0, all 32 registers 0. Reset mid-operation discards the in-flight instruction.
- FlushE=1 at edge: all control outputs and all data/index outputs load 0 (bubble); register-file write in the same edge still happens.
- Reset has priority over flush.
- Write-back to register k and decode reading k in the same cycle: decode sees new value (bypass), no RAW hazard through the file.

## Test plan
- Reset: hold rst=0 two cycles -> all outputs 0; read any register afterwards -> 0.
- Write x5=0xDEADBEEF via WB, then InstrD=0x00028093 (addi x1,x5,0) -> RD1E=0xDEADBEEF, ImmExtE=0, ALUSrcBE=1, RegWriteE=1, RdE=1.
- Same-cycle bypass: RegWriteW=1, RdW=6, ResultW=0x12345678 while InstrD=0x40630133 (sub x2,x6,x6) -> RD1E=RD2E=0x12345678, ALUControlE=0001.
- x0 protection: WB RdW=0, ResultW=0xFFFFFFFF, then read x0 -> RD1E=0.
- Immediates: sw 0xFE112E23 -> ImmExtE=0xFFFFFFFC, MemWriteE=1; beq 0xFE000EE3 -> ImmExtE=0xFFFFFFFC, BranchE=1; jal 0x0000006F at PCD=0x40 -> JumpE=1, PCE=0x40, ResultSrcE=10.
- Flush: FlushE=1 with valid add in InstrD -> next cycle all E outputs 0; following cycle with FlushE=0 decodes normally.
